pdm_mic_capture: RTL and testbench
==================================

PDM_MIC_CAPTURE -- requirements
Module: pdm_mic_capture

Interface
REQ-001 Parameter LINES, default 4: number of PDM data lines, each a stereo mic pair (2*LINES channels).
REQ-002 Parameter CLK_DIV, default 16: clk cycles per mic_clk period; even, >= 4 (48 MHz -> 3.0 MHz).
REQ-003 Parameter WINDOW, default 64: PDM periods per decimated output sample.
REQ-004 Parameter SETTLE, default 4: PDM periods discarded after start.
REQ-005 Localparam CW = clog2(WINDOW+1); default is 7.
REQ-006 clk  input  1  48 MHz PLL output clock; the only clock.
REQ-007 rst  input  1  synchronous, active-high reset.
REQ-008 enable  input  1  capture request; 0 stops capture.
REQ-009 pll_locked  input  1  PLL lock status, synchronous to clk.
REQ-010 pdm_data  input  LINES  mic data lines.
REQ-011 mic_clk  output  1  registered PDM clock to the mics.
REQ-012 out_data  output  2*LINES*CW  ones-count per channel; channel k in bits [k*CW +: CW].
REQ-013 out_valid  output  1  out_data holds an unconsumed sample.
REQ-014 out_ready  input  1  consumer accepts out_data when out_valid=1.
REQ-015 overrun  output  1  sticky: an unconsumed sample was overwritten.
REQ-016 running  output  1  high in RUN state.

Function
REQ-017 One clock, one synchronous active-high reset; no other clock or reset domain.
REQ-018 pdm_data is registered once on every clk; all sampling uses the registered copy.
REQ-019 FSM states are IDLE, SETTLE and RUN; IDLE->SETTLE when enable=1 and pll_locked=1.
REQ-020 SETTLE->RUN after SETTLE complete PDM periods, with no samples counted.
REQ-021 From SETTLE or RUN, enable=0 or pll_locked=0 forces IDLE on the next clk.
REQ-022 In IDLE: divider counter cnt=0, mic_clk=0, accumulators=0, period counter=0.
REQ-023 In SETTLE/RUN, cnt counts 0..CLK_DIV-1 and wraps to 0.
REQ-024 mic_clk is registered: 0 while cnt < CLK_DIV/2, 1 otherwise; 50% duty.
REQ-025 Channel 2i (line i, A) samples at cnt=CLK_DIV/2-1, the last cycle before mic_clk rises.
REQ-026 Channel 2i+1 (line i, B) samples at cnt=CLK_DIV-1, the last cycle before mic_clk falls.
REQ-027 In RUN, each sampled 1 increments that channel's CW-bit accumulator; a 0 leaves it unchanged.
REQ-028 A period counter 0..WINDOW-1 advances at cnt=CLK_DIV-1 in RUN.
REQ-029 At the window's last B sample, out_data loads accumulator plus that cycle's sample for every channel.
REQ-030 In that same cycle the accumulators clear to 0; no sample is lost or double-counted.
REQ-031 Maximum per-channel value is WINDOW; it never wraps.
REQ-032 out_valid rises on the cycle after a load.
REQ-033 out_valid and out_data hold until a cycle with out_ready=1; out_valid then clears.
REQ-034 Load while out_valid=1 and out_ready=0: out_data is overwritten, out_valid stays 1, overrun sets.
REQ-035 Load while out_valid=1 and out_ready=1: the old sample is consumed, the new one loads, out_valid stays 1, overrun unchanged.
REQ-036 overrun clears only on rst or in IDLE.
REQ-037 On entry to IDLE a pending out_valid is kept until consumed; a partial window is discarded.

Reset
REQ-038 On rst=1 at a clk edge: FSM=IDLE, mic_clk=0, out_valid=0, out_data=0, overrun=0, running=0, all counters and accumulators 0.
REQ-039 rst takes precedence over all other inputs, including mid-window and during a handshake.

Verification
REQ-040 Startup: rst, then enable=1, pll_locked=1 -> running rises after 4*16 clk; mic_clk period is 16 clk, 8 high / 8 low.
REQ-041 All ones on pdm_data=4'hF with out_ready=1 -> every 64*16 clk out_valid pulses; every field =64; overrun=0.
REQ-042 Channel split: line 0 driven 1 only in the 8 clk before each mic_clk rise -> ch0=64, ch1=0, others 0.
REQ-043 Backpressure: out_ready=0 for two windows -> overrun=1, out_data = second window value; out_ready=1 -> out_valid drops next cycle.
REQ-044 Lock loss: pll_locked=0 mid-window -> IDLE next clk, mic_clk=0, no partial sample; on relock, SETTLE repeats.
REQ-045 Simultaneous event: out_ready=1 on the exact load cycle -> out_valid stays 1 with new data; overrun stays 0.

Source files
------------

// File: rtl/pdm_mic_capture.sv
// -----------------------------------------------------------------------------
// pdm_mic_capture
//
// Purpose:
//   Drives a shared PDM clock to LINES stereo microphone pairs and decimates
//   each of the 2*LINES one-bit streams into a ones-count over a fixed window
//   of WINDOW PDM periods. After start (enable and PLL lock), SETTLE PDM
//   periods are discarded while the microphones wake up. Completed windows
//   are presented on a valid/ready output with a sticky overrun flag.
//
//   On each data line the "A" mic drives its bit while mic_clk is low and the
//   "B" mic drives while mic_clk is high, so A is sampled on the last clk
//   before mic_clk rises and B on the last clk before it falls.
//
// Parameters:
//   LINES   number of PDM data lines (2*LINES channels)
//   CLK_DIV clk cycles per mic_clk period (even, >= 4)
//   WINDOW  PDM periods per output sample
//   SETTLE  PDM periods discarded after start (>= 1)
//   CW      ones-count width, clog2(WINDOW+1)
//
// Ports:
//   clk         the only clock
//   rst         synchronous, active-high reset
//   enable      capture request; 0 stops capture
//   pll_locked  PLL lock status, synchronous to clk
//   pdm_data    PDM data lines, one per stereo pair
//   mic_clk     registered PDM clock to the microphones
//   out_data    per-channel ones-count, channel k in [k*CW +: CW]
//                 channel 2i = line i A mic, channel 2i+1 = line i B mic
//   out_valid   out_data holds an unconsumed sample
//   out_ready   consumer accepts out_data when out_valid=1
//   overrun     sticky: an unconsumed sample was overwritten (cleared in IDLE)
//   running     high while in RUN
// -----------------------------------------------------------------------------
module pdm_mic_capture #(
  parameter  int LINES   = 4,
  parameter  int CLK_DIV = 16,
  parameter  int WINDOW  = 64,
  parameter  int SETTLE  = 4,
  localparam int CW      = $clog2(WINDOW + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  pll_locked,
  input  logic [LINES-1:0]      pdm_data,
  output logic                  mic_clk,
  output logic [2*LINES*CW-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  overrun,
  output logic                  running
);

  localparam int NCH  = 2 * LINES;
  localparam int HALF = CLK_DIV / 2;
  localparam int CNTW = $clog2(CLK_DIV);
  localparam int PMAX = (WINDOW > SETTLE) ? WINDOW : SETTLE;
  localparam int PW   = $clog2(PMAX + 1);

  localparam logic [CNTW-1:0] CNT_A_SAMPLE = CNTW'(HALF - 1);
  localparam logic [CNTW-1:0] CNT_B_SAMPLE = CNTW'(CLK_DIV - 1);
  localparam logic [CNTW-1:0] CNT_HALF     = CNTW'(HALF);
  localparam logic [PW-1:0]   SETTLE_LAST  = PW'(SETTLE - 1);
  localparam logic [PW-1:0]   WINDOW_LAST  = PW'(WINDOW - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_RUN    = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [CNTW-1:0]       cnt_q, cnt_d;
  logic [PW-1:0]         period_q, period_d;
  logic                  mic_clk_q, mic_clk_d;
  logic [LINES-1:0]      pdm_q;
  logic [2*LINES*CW-1:0] out_data_q, out_data_d;
  logic                  out_valid_q, out_valid_d;
  logic                  overrun_q, overrun_d;

  logic                  go;
  logic                  at_a;
  logic                  at_b;
  logic                  in_run;
  logic                  samp_a;
  logic                  samp_b;
  logic                  win_end;
  logic [CW-1:0]         sum_w [NCH];

  assign go   = enable & pll_locked;
  assign at_a = (cnt_q == CNT_A_SAMPLE);
  assign at_b = (cnt_q == CNT_B_SAMPLE);

  // Counting only happens in RUN cycles that are not being aborted; a cycle
  // in which enable or lock drops already belongs to the discarded window.
  assign in_run  = (state_q == ST_RUN) & go;
  assign samp_a  = in_run & at_a;
  assign samp_b  = in_run & at_b;
  assign win_end = samp_b & (period_q == WINDOW_LAST);

  // ---------------------------------------------------------------------------
  // Input register: every sampling decision uses this copy of pdm_data.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      pdm_q <= '0;
    end else begin
      pdm_q <= pdm_data;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM, clock divider and period counter
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      period_q  <= '0;
      mic_clk_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      period_q  <= period_d;
      mic_clk_q <= mic_clk_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    period_d = period_q;
    cnt_d    = '0;

    case (state_q)
      ST_IDLE: begin
        period_d = '0;
        if (go) begin
          state_d = ST_SETTLE;
        end
      end

      // The period counter doubles as the settle counter; it is back at 0 on
      // the first RUN cycle so windows align to the first full PDM period.
      ST_SETTLE: begin
        if (!go) begin
          state_d = ST_IDLE;
        end else if (at_b) begin
          if (period_q == SETTLE_LAST) begin
            state_d  = ST_RUN;
            period_d = '0;
          end else begin
            period_d = period_q + 1'b1;
          end
        end
      end

      ST_RUN: begin
        if (!go) begin
          state_d = ST_IDLE;
        end else if (at_b) begin
          period_d = (period_q == WINDOW_LAST) ? '0 : period_q + 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (state_d == ST_IDLE) begin
      period_d = '0;
    end

    // The divider only runs between two active cycles, so the first SETTLE
    // cycle always starts at cnt=0 and leaving SETTLE/RUN returns it to 0.
    if ((state_q != ST_IDLE) && (state_d != ST_IDLE)) begin
      cnt_d = at_b ? '0 : cnt_q + 1'b1;
    end

    // Registered from the next count, so mic_clk lines up with cnt_q.
    mic_clk_d = (cnt_d >= CNT_HALF);
  end

  // ---------------------------------------------------------------------------
  // Per-channel accumulators. Even channels take the A sample, odd channels
  // the B sample of the same line. sum_w includes this cycle's sample, so
  // the last B sample of a window lands in the output, not the next window.
  // ---------------------------------------------------------------------------
  for (genvar gi = 0; gi < NCH; gi++) begin : g_chan
    localparam int LINE = gi / 2;

    logic          hit;
    logic [CW-1:0] acc_q, acc_d;

    assign hit        = ((gi % 2 == 0) ? samp_a : samp_b) & pdm_q[LINE];
    assign sum_w[gi]  = acc_q + CW'(hit);

    always_comb begin
      acc_d = sum_w[gi];
      if (!in_run || win_end) begin
        acc_d = '0;
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        acc_q <= '0;
      end else begin
        acc_q <= acc_d;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Output register with valid/ready handshake and sticky overrun
  // ---------------------------------------------------------------------------
  always_comb begin
    out_data_d = out_data_q;
    if (win_end) begin
      for (int k = 0; k < NCH; k++) begin
        out_data_d[k*CW +: CW] = sum_w[k];
      end
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    overrun_d   = overrun_q;
    if (win_end) begin
      // A load always leaves valid set; the previous sample was either
      // consumed this same cycle or is lost.
      out_valid_d = 1'b1;
      if (out_valid_q && !out_ready) begin
        overrun_d = 1'b1;
      end
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end

    // A pending sample survives IDLE, but the overrun history does not.
    if (state_q == ST_IDLE) begin
      overrun_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      overrun_q   <= overrun_d;
    end
  end

  assign mic_clk   = mic_clk_q;
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign overrun   = overrun_q;
  assign running   = (state_q == ST_RUN);

endmodule

// File: tb/tb_pdm_mic_capture.sv
// -----------------------------------------------------------------------------
// tb_pdm_mic_capture
//
// Self-checking bench for pdm_mic_capture with default parameters. Each
// window's line pattern comes from a table; the expected per-channel counts
// are pushed to a scoreboard queue when that window's stimulus starts and
// popped when the sample is due. A small output-register model tracks
// out_valid/out_data/overrun through the handshake. Hand-written sequences
// cover startup, backpressure, lock loss, the simultaneous load/consume case
// and a mid-run reset.
// -----------------------------------------------------------------------------
module tb_pdm_mic_capture;

  localparam int L         = 4;
  localparam int D         = 16;
  localparam int W         = 64;
  localparam int S         = 4;
  localparam int CW        = 7;
  localparam int DW        = 2 * L * CW;
  localparam int WCYC      = W * D;
  localparam int RUN_START = S * D;
  localparam int NV        = 7;

  logic          clk        = 1'b0;
  logic          rst        = 1'b1;
  logic          enable     = 1'b0;
  logic          pll_locked = 1'b0;
  logic          out_ready  = 1'b0;
  logic [L-1:0]  pdm_data   = '0;
  logic          mic_clk;
  logic          out_valid;
  logic          overrun;
  logic          running;
  logic [DW-1:0] out_data;

  pdm_mic_capture #(
    .LINES   (L),
    .CLK_DIV (D),
    .WINDOW  (W),
    .SETTLE  (S)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .pll_locked (pll_locked),
    .pdm_data   (pdm_data),
    .mic_clk    (mic_clk),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .overrun    (overrun),
    .running    (running)
  );

  always #5 clk = ~clk;

  // A line's A bit is 1 in periods p < ka, its B bit in periods p >= W-kb.
  // noisy=1 drives random data everywhere except the two sampled cycles.
  typedef struct {
    logic [L-1:0]  a_lines;
    logic [L-1:0]  b_lines;
    int            ka;
    int            kb;
    bit            noisy;
    logic [DW-1:0] exp_val;
  } vec_t;

  typedef struct {
    logic [DW-1:0] data;
    int            due_neg;
  } sb_t;

  vec_t          tbl [NV];
  sb_t           exp_q [$];

  int            n_tests       = 0;
  int            n_fail        = 0;
  int            negcnt        = 0;
  int            c             = 0;
  int            pat_base      = 0;
  bit            tb_active     = 1'b0;
  bit            start_pending = 1'b0;
  bit            stop_pending  = 1'b0;
  bit            m_valid       = 1'b0;
  bit            m_ovr         = 1'b0;
  logic [DW-1:0] m_data        = '0;

  function automatic vec_t mk(input logic [L-1:0] a, input logic [L-1:0] b,
                              input int ka, input int kb, input bit noisy);
    vec_t v;
    int   val;
    v.a_lines = a;
    v.b_lines = b;
    v.ka      = ka;
    v.kb      = kb;
    v.noisy   = noisy;
    v.exp_val = '0;
    for (int k = 0; k < 2 * L; k++) begin
      if (k % 2 == 0) val = a[k/2] ? ka : 0;
      else            val = b[k/2] ? kb : 0;
      v.exp_val[k*CW +: CW] = CW'(val);
    end
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      if (n_fail <= 40)
        $display("FAIL %s: got 0x%0h, required 0x%0h (negedge %0d)", name, act, req, negcnt);
    end
  endtask

  task automatic fail_now(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: event not reached, required it (negedge %0d)", name, negcnt);
  endtask

  // One clk cycle: update the model for the edge just taken, compare every
  // output, then drive pdm_data for the current cycle.
  task automatic run_cycle();
    bit   due;
    int   r;
    int   w;
    int   p;
    int   ph;
    vec_t v;
    sb_t  e;
    @(negedge clk);
    negcnt++;
    if (rst) begin
      m_valid       = 1'b0;
      m_data        = '0;
      m_ovr         = 1'b0;
      tb_active     = 1'b0;
      start_pending = 1'b0;
      stop_pending  = 1'b0;
      c             = 0;
      exp_q.delete();
    end else begin
      if (!tb_active) m_ovr = 1'b0;
      due = (exp_q.size() > 0) && (exp_q[0].due_neg == negcnt);
      if (due) begin
        if (m_valid && !out_ready) m_ovr = 1'b1;
        m_valid = 1'b1;
        m_data  = exp_q[0].data;
        void'(exp_q.pop_front());
      end else if (m_valid && out_ready) begin
        m_valid = 1'b0;
      end
      if (tb_active) c++;
      if (start_pending) begin
        tb_active     = 1'b1;
        c             = 0;
        start_pending = 1'b0;
      end
      if (stop_pending) begin
        exp_q.delete();
        tb_active    = 1'b0;
        stop_pending = 1'b0;
      end
    end

    chk("mic_clk",   64'(mic_clk),   64'(tb_active && ((c % D) >= D / 2)));
    chk("running",   64'(running),   64'(tb_active && (c >= RUN_START)));
    chk("out_valid", 64'(out_valid), 64'(m_valid));
    chk("overrun",   64'(overrun),   64'(m_ovr));
    chk("out_data",  64'(out_data),  64'(m_data));

    pdm_data = L'($urandom);
    if (tb_active && (c >= RUN_START)) begin
      r  = c - RUN_START;
      w  = r / WCYC;
      p  = (r / D) % W;
      ph = c % D;
      v  = tbl[(pat_base + w) % NV];
      if (r % WCYC == 0) begin
        e.data    = v.exp_val;
        e.due_neg = negcnt + WCYC;
        exp_q.push_back(e);
      end
      for (int i = 0; i < L; i++) begin
        if (ph < D / 2) begin
          if (!v.noisy || ph == D / 2 - 2) pdm_data[i] = v.a_lines[i] && (p < v.ka);
        end else begin
          if (!v.noisy || ph == D - 2) pdm_data[i] = v.b_lines[i] && (p >= W - v.kb);
        end
      end
    end
  endtask

  task automatic run_n(input int n);
    for (int k = 0; k < n; k++) run_cycle();
  endtask

  task automatic run_to(input int target);
    for (int k = 0; k < 3000 && negcnt < target; k++) run_cycle();
    chk("reach_target", 64'(negcnt), 64'(target));
  endtask

  task automatic run_until_due();
    if (exp_q.size() == 0) begin
      fail_now("no_pending_window");
    end else begin
      run_to(exp_q[0].due_neg);
    end
  endtask

  task automatic wait_running(output int k);
    k = 0;
    do begin
      run_cycle();
      k++;
    end while (!running && k < 200);
  endtask

  initial begin
    int   k;
    int   highs;
    int   rises;
    int   seen;
    int   d;
    logic prev;

    tbl[0] = mk(4'hF, 4'hF, 64, 64, 1'b0);
    tbl[1] = mk(4'h1, 4'h0, 64,  0, 1'b0);
    tbl[2] = mk(4'h5, 4'hA,  1,  1, 1'b1);
    tbl[3] = mk(4'hF, 4'hF, 64, 64, 1'b1);
    tbl[4] = mk(4'hC, 4'h3, 63, 32, 1'b1);
    tbl[5] = mk(4'h0, 4'h0,  0,  0, 1'b1);
    tbl[6] = mk(4'h9, 4'h6, 17, 64, 1'b1);

    // Reset state
    rst = 1'b1;
    run_n(3);
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_out_data",  64'(out_data),  64'(0));
    chk("rst_overrun",   64'(overrun),   64'(0));
    chk("rst_running",   64'(running),   64'(0));
    chk("rst_mic_clk",   64'(mic_clk),   64'(0));
    rst = 1'b0;
    run_n(4);

    // Startup: SETTLE lasts S*D clk, mic_clk toggles 8 high / 8 low
    pat_base      = 0;
    out_ready     = 1'b1;
    enable        = 1'b1;
    pll_locked    = 1'b1;
    start_pending = 1'b1;
    k = 0; highs = 0; rises = 0; prev = 1'b0;
    do begin
      run_cycle();
      k++;
      if (!running) begin
        if (mic_clk) highs++;
        if (mic_clk && !prev) rises++;
        prev = mic_clk;
      end
    end while (!running && k < 200);
    chk("startup_edges",   64'(k - 1), 64'(RUN_START));
    chk("settle_mic_high", 64'(highs), 64'(RUN_START / 2));
    chk("settle_mic_rises", 64'(rises), 64'(S));

    // Table windows with out_ready held high
    for (int i = 0; i < NV; i++) begin
      k = 0;
      do begin
        run_cycle();
        k++;
      end while (!out_valid && k < WCYC + 200);
      chk($sformatf("tbl%0d_valid", i), 64'(out_valid), 64'(1));
      chk($sformatf("tbl%0d_data", i),  64'(out_data),  64'(tbl[i].exp_val));
    end

    // Backpressure over two windows
    run_cycle();
    out_ready = 1'b0;
    run_until_due();
    chk("bp_first_valid",   64'(out_valid), 64'(1));
    chk("bp_first_overrun", 64'(overrun),   64'(0));
    run_until_due();
    chk("bp_overrun", 64'(overrun),  64'(1));
    chk("bp_data",    64'(out_data), 64'(tbl[1].exp_val));
    out_ready = 1'b1;
    run_cycle();
    chk("bp_valid_drop", 64'(out_valid), 64'(0));

    // Lock loss mid-window with a sample pending
    out_ready = 1'b0;
    run_until_due();
    run_n(300);
    pll_locked   = 1'b0;
    stop_pending = 1'b1;
    run_cycle();
    chk("lock_running", 64'(running), 64'(0));
    chk("lock_mic_clk", 64'(mic_clk), 64'(0));
    run_n(20);
    chk("lock_keep_valid",  64'(out_valid), 64'(1));
    chk("lock_keep_data",   64'(out_data),  64'(tbl[2].exp_val));
    chk("lock_overrun_clr", 64'(overrun),   64'(0));
    out_ready = 1'b1;
    run_cycle();
    chk("lock_consumed", 64'(out_valid), 64'(0));
    seen = 0;
    for (int j = 0; j < WCYC + 76; j++) begin
      run_cycle();
      if (out_valid) seen++;
    end
    chk("no_partial_sample", 64'(seen), 64'(0));

    // Relock: SETTLE repeats
    pat_base      = 4;
    pll_locked    = 1'b1;
    start_pending = 1'b1;
    wait_running(k);
    chk("relock_settle_edges", 64'(k - 1), 64'(RUN_START));

    // out_ready rises exactly on the load cycle with a sample pending
    run_until_due();
    run_cycle();
    out_ready = 1'b0;
    run_until_due();
    if (exp_q.size() == 0) begin
      fail_now("simul_no_window");
    end else begin
      d = exp_q[0].due_neg;
      run_to(d - 1);
      out_ready = 1'b1;
      run_cycle();
      chk("simul_valid",   64'(out_valid), 64'(1));
      chk("simul_data",    64'(out_data),  64'(tbl[6].exp_val));
      chk("simul_overrun", 64'(overrun),   64'(0));
      run_cycle();
      chk("simul_consumed", 64'(out_valid), 64'(0));
    end

    // Reset mid-window with a sample pending
    out_ready = 1'b0;
    run_until_due();
    run_n(100);
    rst    = 1'b1;
    enable = 1'b0;
    run_cycle();
    chk("midrst_out_valid", 64'(out_valid), 64'(0));
    chk("midrst_out_data",  64'(out_data),  64'(0));
    chk("midrst_overrun",   64'(overrun),   64'(0));
    chk("midrst_running",   64'(running),   64'(0));
    chk("midrst_mic_clk",   64'(mic_clk),   64'(0));
    rst = 1'b0;
    run_n(5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
